// File: rtl/noc_pkg.sv
// noc_pkg: constants and helpers shared by the node network interface.
//   ADDR_W        width of a node address
//   FLIT_*_HI/LO  bit offsets of the address fields, measured above the
//                 payload: a flit is {dest, src, data}, so with DATA_W bits
//                 of payload the dest field is flit[DATA_W+3:DATA_W+2]
//   flit_w()      full flit width for a given payload width
package noc_pkg;

  localparam int ADDR_W = 2;

  localparam int FLIT_DEST_HI = 3;
  localparam int FLIT_DEST_LO = 2;
  localparam int FLIT_SRC_HI  = 1;
  localparam int FLIT_SRC_LO  = 0;

  function automatic int flit_w(input int data_w);
    return data_w + 2 * ADDR_W;
  endfunction

endpackage

// File: rtl/ni_fifo.sv
// ni_fifo: show-ahead synchronous FIFO with async active-high reset.
//   clk, rst    clock / asynchronous active-high reset
//   push        write push_data (ignored while full)
//   push_data   WIDTH-bit write data
//   pop         drop the head entry (ignored while empty)
//   pop_data    head entry, valid whenever empty is low
//   full        occupancy == DEPTH
//   empty       occupancy == 0
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module ni_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Flags come straight from the registered count, so ready/valid seen by
  // neighbours never depend combinationally on this cycle's inputs.
  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {(AW + 1){1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage write; contents are not reset, only the pointers/count are.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1'b1);
        2'b01:   count_r <= count_r - (AW + 1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/network_interface.sv
// network_interface: node-side NI between a MIPS core and its router port.
//   clk, rst                          clock / async active-high reset
//   proc_data, dest_add, proc_valid   processor payload in
//   mips_ni                           NI can take a processor payload
//   flit_out, flit_out_valid/_ready   flit {dest,src,data} to router
//   flit_in, flit_in_valid/_ready     flit {dest,src,data} from router
//   ni_data, ni_src, data_valid       delivered payload to processor
//   proc_ready_in                     processor takes ni_data
//   misroute_cnt                      saturating count of dropped flits
// Flits addressed to another node are consumed and counted, never stored.
module network_interface
  import noc_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [ADDR_W-1:0] NODE_ID = 2'b00,
  parameter int                DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           proc_data,
  input  logic [ADDR_W-1:0]           dest_add,
  input  logic                        proc_valid,
  output logic                        mips_ni,
  output logic [flit_w(DATA_W)-1:0]   flit_out,
  output logic                        flit_out_valid,
  input  logic                        flit_out_ready,
  input  logic [flit_w(DATA_W)-1:0]   flit_in,
  input  logic                        flit_in_valid,
  output logic                        flit_in_ready,
  output logic [DATA_W-1:0]           ni_data,
  output logic [ADDR_W-1:0]           ni_src,
  output logic                        data_valid,
  input  logic                        proc_ready_in,
  output logic [7:0]                  misroute_cnt
);

  localparam int FW  = flit_w(DATA_W);
  localparam int RXW = DATA_W + ADDR_W;

  logic          tx_full_s;
  logic          tx_empty_s;
  logic          tx_push_s;
  logic [FW-1:0] tx_din_s;

  logic           rx_full_s;
  logic           rx_empty_s;
  logic           rx_accept_s;
  logic           dest_hit_s;
  logic           rx_push_s;
  logic           misroute_s;
  logic [RXW-1:0] rx_din_s;
  logic [RXW-1:0] rx_head_s;

  logic [7:0] misroute_cnt_r;

  // TX side: pack and push; the router sees the head entry directly.
  assign mips_ni        = !tx_full_s;
  assign flit_out_valid = !tx_empty_s;
  assign tx_push_s      = proc_valid && !tx_full_s;
  assign tx_din_s       = {dest_add, NODE_ID, proc_data};

  ni_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push_s),
    .push_data (tx_din_s),
    .pop       (flit_out_valid && flit_out_ready),
    .pop_data  (flit_out),
    .full      (tx_full_s),
    .empty     (tx_empty_s)
  );

  // RX side: a flit is consumed whenever ready, but only stored if it is ours.
  assign flit_in_ready = !rx_full_s;
  assign rx_accept_s   = flit_in_valid && !rx_full_s;
  assign dest_hit_s    = (flit_in[DATA_W+FLIT_DEST_HI:DATA_W+FLIT_DEST_LO] == NODE_ID);
  assign rx_push_s     = rx_accept_s && dest_hit_s;
  assign misroute_s    = rx_accept_s && !dest_hit_s;
  assign rx_din_s      = {flit_in[DATA_W+FLIT_SRC_HI:DATA_W+FLIT_SRC_LO], flit_in[DATA_W-1:0]};

  ni_fifo #(
    .WIDTH (RXW),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push_s),
    .push_data (rx_din_s),
    .pop       (data_valid && proc_ready_in),
    .pop_data  (rx_head_s),
    .full      (rx_full_s),
    .empty     (rx_empty_s)
  );

  assign data_valid = !rx_empty_s;
  assign ni_src     = rx_head_s[RXW-1:DATA_W];
  assign ni_data    = rx_head_s[DATA_W-1:0];

  // Misroute counter, saturating at 255 so it never wraps back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misroute_cnt_r <= 8'd0;
    end else if (misroute_s && (misroute_cnt_r != 8'hFF)) begin
      misroute_cnt_r <= misroute_cnt_r + 8'd1;
    end else begin
      misroute_cnt_r <= misroute_cnt_r;
    end
  end

  assign misroute_cnt = misroute_cnt_r;

endmodule

// File: tb/tb_network_interface.sv
// Self-checking bench for network_interface (NODE_ID = 1, DEPTH = 4).
// A queue-based model tracks what each FIFO must hold; a compare process
// checks every output against it on each falling edge, and directed steps
// add literal expectations for the scenarios of interest.
module tb_network_interface;

  localparam int               DATA_W  = 32;
  localparam int               DEPTH   = 4;
  localparam logic [1:0]       NODE_ID = 2'b01;

  logic        clk;
  logic        rst;
  logic [31:0] proc_data;
  logic [1:0]  dest_add;
  logic        proc_valid;
  logic        mips_ni;
  logic [35:0] flit_out;
  logic        flit_out_valid;
  logic        flit_out_ready;
  logic [35:0] flit_in;
  logic        flit_in_valid;
  logic        flit_in_ready;
  logic [31:0] ni_data;
  logic [1:0]  ni_src;
  logic        data_valid;
  logic        proc_ready_in;
  logic [7:0]  misroute_cnt;

  network_interface #(
    .DATA_W  (DATA_W),
    .NODE_ID (NODE_ID),
    .DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .proc_data      (proc_data),
    .dest_add       (dest_add),
    .proc_valid     (proc_valid),
    .mips_ni        (mips_ni),
    .flit_out       (flit_out),
    .flit_out_valid (flit_out_valid),
    .flit_out_ready (flit_out_ready),
    .flit_in        (flit_in),
    .flit_in_valid  (flit_in_valid),
    .flit_in_ready  (flit_in_ready),
    .ni_data        (ni_data),
    .ni_src         (ni_src),
    .data_valid     (data_valid),
    .proc_ready_in  (proc_ready_in),
    .misroute_cnt   (misroute_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [35:0] tx_q[$];
  logic [33:0] rx_q[$];
  int          mis_m = 0;
  bit          m_tx_push, m_tx_pop, m_rx_acc, m_rx_pop;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        tx_q.delete();
        rx_q.delete();
        mis_m = 0;
      end else begin
        m_tx_push = proc_valid && (tx_q.size() < DEPTH);
        m_tx_pop  = (tx_q.size() > 0) && flit_out_ready;
        m_rx_acc  = flit_in_valid && (rx_q.size() < DEPTH);
        m_rx_pop  = (rx_q.size() > 0) && proc_ready_in;
        if (m_tx_pop)  void'(tx_q.pop_front());
        if (m_tx_push) tx_q.push_back({dest_add, NODE_ID, proc_data});
        if (m_rx_pop)  void'(rx_q.pop_front());
        if (m_rx_acc) begin
          if (flit_in[35:34] == NODE_ID) rx_q.push_back(flit_in[33:0]);
          else if (mis_m < 255) mis_m = mis_m + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("mips_ni",        mips_ni,        tx_q.size() < DEPTH);
      chk("flit_out_valid", flit_out_valid, tx_q.size() > 0);
      if (tx_q.size() > 0) chk("flit_out", flit_out, tx_q[0]);
      chk("flit_in_ready",  flit_in_ready,  rx_q.size() < DEPTH);
      chk("data_valid",     data_valid,     rx_q.size() > 0);
      if (rx_q.size() > 0) begin
        chk("ni_src",  ni_src,  rx_q[0][33:32]);
        chk("ni_data", ni_data, rx_q[0][31:0]);
      end
      chk("misroute_cnt", misroute_cnt, mis_m);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    proc_data = 32'd0; dest_add = 2'd0; proc_valid = 1'b0;
    flit_out_ready = 1'b0; flit_in = 36'd0; flit_in_valid = 1'b0;
    proc_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mips_ni",        mips_ni,        1'b1);
    chk("rst_flit_in_ready",  flit_in_ready,  1'b1);
    chk("rst_flit_out_valid", flit_out_valid, 1'b0);
    chk("rst_data_valid",     data_valid,     1'b0);
    chk("rst_misroute",       misroute_cnt,   8'd0);

    // single flit, router always ready: valid for exactly one cycle
    proc_valid = 1'b1; dest_add = 2'd2; proc_data = 32'hDEADBEEF; flit_out_ready = 1'b1;
    tick();
    proc_valid = 1'b0;
    chk("tx1_valid", flit_out_valid, 1'b1);
    chk("tx1_flit",  flit_out, {2'd2, 2'd1, 32'hDEADBEEF});
    tick();
    chk("tx1_one_cycle", flit_out_valid, 1'b0);

    // fill TX while router stalls, 5th push ignored, then drain in order
    flit_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      proc_valid = 1'b1; dest_add = 2'd3; proc_data = i;
      tick();
      if (i == 4) chk("tx_full_mips_ni", mips_ni, 1'b0);
    end
    proc_valid = 1'b0;
    flit_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("tx_drain_order", flit_out[31:0], i);
      tick();
    end
    chk("tx_drained", flit_out_valid, 1'b0);

    // streaming: simultaneous push and pop each cycle
    for (int i = 0; i < 6; i++) begin
      proc_valid = 1'b1; dest_add = i[1:0]; proc_data = 32'hA000_0000 + i;
      tick();
    end
    proc_valid = 1'b0;
    tick();
    flit_out_ready = 1'b0;

    // RX delivery held until processor ready
    flit_in = {2'd1, 2'd3, 32'h12345678}; flit_in_valid = 1'b1; proc_ready_in = 1'b0;
    tick();
    flit_in_valid = 1'b0;
    repeat (3) begin
      chk("rx_hold_valid", data_valid, 1'b1);
      chk("rx_hold_data",  ni_data,    32'h12345678);
      chk("rx_hold_src",   ni_src,     2'd3);
      tick();
    end
    proc_ready_in = 1'b1;
    tick();
    proc_ready_in = 1'b0;
    chk("rx_one_pop", data_valid, 1'b0);

    // 300 misaddressed flits: none delivered, counter saturates
    for (int i = 0; i < 300; i++) begin
      flit_in = {2'd0, 2'd2, 32'd0 + i}; flit_in_valid = 1'b1;
      tick();
    end
    flit_in_valid = 1'b0;
    chk("mis_saturate",  misroute_cnt,  8'd255);
    chk("mis_none_kept", data_valid,    1'b0);
    chk("mis_ready",     flit_in_ready, 1'b1);

    // RX full: simultaneous pop and offer -> refused, then accepted next cycle
    for (int i = 0; i < 4; i++) begin
      flit_in = {2'd1, 2'd2, 32'd10 + i}; flit_in_valid = 1'b1;
      tick();
    end
    flit_in = {2'd1, 2'd2, 32'd14}; proc_ready_in = 1'b1;
    chk("rx_full_ready", flit_in_ready, 1'b0);
    tick();
    proc_ready_in = 1'b0;
    chk("rx_pop_reready", flit_in_ready, 1'b1);
    chk("rx_head_after_pop", ni_data, 32'd11);
    tick();
    flit_in_valid = 1'b0;
    chk("rx_refull", flit_in_ready, 1'b0);
    proc_ready_in = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      chk("rx_order", ni_data, i);
      tick();
    end
    proc_ready_in = 1'b0;
    chk("rx_drained", data_valid, 1'b0);

    // asynchronous reset with 2 entries in each FIFO
    for (int i = 0; i < 2; i++) begin
      proc_valid = 1'b1; dest_add = 2'd0; proc_data = 32'hB0 + i;
      flit_in = {2'd1, 2'd0, 32'hC0 + i}; flit_in_valid = 1'b1;
      tick();
    end
    proc_valid = 1'b0; flit_in_valid = 1'b0;
    chk("pre_rst_tx", flit_out_valid, 1'b1);
    chk("pre_rst_rx", data_valid,     1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_data_valid",     data_valid,     1'b0);
    chk("arst_flit_out_valid", flit_out_valid, 1'b0);
    chk("arst_mips_ni",        mips_ni,        1'b1);
    chk("arst_flit_in_ready",  flit_in_ready,  1'b1);
    chk("arst_misroute",       misroute_cnt,   8'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // traffic resumes normally after reset
    proc_valid = 1'b1; dest_add = 2'd1; proc_data = 32'h5A5A5A5A; flit_out_ready = 1'b1;
    tick();
    proc_valid = 1'b0;
    chk("post_rst_flit", flit_out, {2'd1, 2'd1, 32'h5A5A5A5A});
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/network_interface.md
# network_interface

Node-side network interface that pairs with the MIPS decode/control handshake. It accepts single-flit packets from the processor on the `proc_valid`/`mips_ni` handshake, buffers them, and injects them into the router port. In the other direction it accepts flits from the router, buffers them, and presents them to the processor on the `data_valid`/`proc_ready_in` handshake. It sits between the MIPS core and its local router port, one instance per node.

## Interface
Parameters:
- `DATA_W`, 32, payload width.
- `NODE_ID`, 2'b00, this node's 2-bit address.
- `DEPTH`, 4, entries per FIFO; must be a power of two, ≥ 2.

Ports (clock and reset first; one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `proc_data`  in  DATA_W  processor payload (ALU result).
- `dest_add`  in  2  destination node from the processor.
- `proc_valid`  in  1  processor payload valid.
- `mips_ni`  out  1  NI can accept a processor payload.
- `flit_out`  out  DATA_W+4  flit to router, {dest[1:0], src[1:0], data}.
- `flit_out_valid`  out  1  `flit_out` valid.
- `flit_out_ready`  in  1  router accepts `flit_out`.
- `flit_in`  in  DATA_W+4  flit from router, same format.
- `flit_in_valid`  in  1  `flit_in` valid.
- `flit_in_ready`  out  1  NI accepts `flit_in`.
- `ni_data`  out  DATA_W  payload to processor.
- `ni_src`  out  2  source node of `ni_data`.
- `data_valid`  out  1  `ni_data` valid.
- `proc_ready_in`  in  1  processor accepts `ni_data`.
- `misroute_cnt`  out  8  saturating count of dropped misaddressed flits.

## Operation
- TX path:
  - `mips_ni` = TX FIFO not full.
  - A push occurs when `proc_valid && mips_ni`, storing {`dest_add`, `NODE_ID`, `proc_data`}.
  - A flit may target `NODE_ID` itself; it is still sent to the router, with no local loopback.
- TX FIFO is show-ahead:
  - `flit_out_valid` = not empty and `flit_out` = head entry.
  - A pop occurs when `flit_out_valid && flit_out_ready`.
  - `flit_out` holds stable while valid and not accepted.
- RX path:
  - `flit_in_ready` = RX FIFO not full.
  - On `flit_in_valid && flit_in_ready`:
    - If `flit_in[DATA_W+3:DATA_W+2] == NODE_ID`, push {src, data}.
    - Otherwise consume the flit without storing it, and increment `misroute_cnt`, saturating at 255.
- RX FIFO is show-ahead:
  - `data_valid` = not empty, and `ni_data`/`ni_src` = head entry.
  - A pop occurs on `data_valid && proc_ready_in`.
- FIFO rules:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy count is log2(DEPTH)+1 bits.
  - Full means count == DEPTH; empty means count == 0.
- Simultaneous push and pop:
  - Non-empty, non-full: count unchanged, both pointers advance.
  - Full: push is refused because ready is low; the pop proceeds.
  - Empty: only the push takes effect (no bypass).
- Reset, asynchronous at any time, including mid-transfer:
  - Pointers, counts and `misroute_cnt` clear to 0; FIFO contents are discarded.
  - Output values after reset: `mips_ni`=1, `flit_in_ready`=1, `flit_out_valid`=0, `data_valid`=0, `misroute_cnt`=0.
  - `flit_out`, `ni_data` and `ni_src` are don't-care while their valid is 0.

## Timing
- All ready/valid outputs are combinational decodes of registered counts only. No input-to-output combinational path exists.
- TX latency: a push at edge N gives `flit_out_valid`=1 in the cycle after N. Minimum is 1 cycle from processor to router.
- RX latency: an accepted flit at edge N gives `data_valid`=1 in the cycle after N.
- Throughput: one push and one pop per FIFO per cycle.
- A full FIFO with a pop at edge N re-asserts ready in the cycle after N.
- `misroute_cnt` updates at the same edge the flit is consumed.

## Structure
- Shared package `noc_pkg`:
  - `FLIT_DEST_HI`/`LO` and `FLIT_SRC_HI`/`LO` field positions.
  - `ADDR_W`=2.
  - A flit width function of `DATA_W`.
- One sub-module, `ni_fifo`: parameterised width/depth, show-ahead, synchronous push/pop, async active-high reset, full/empty outputs.
  - Instantiated twice: TX at width DATA_W+4, RX at width DATA_W+2.
- Top level adds flit packing, the destination filter and the saturating counter.

## Test plan
- Reset, then `proc_valid`=1, `dest_add`=2, `proc_data`=0xDEADBEEF, NODE_ID=1, `flit_out_ready`=1 → next cycle `flit_out`={2,1,0xDEADBEEF} and `flit_out_valid`=1 for exactly one cycle.
- Hold `flit_out_ready`=0 and push 4 words → `mips_ni` falls after the 4th push. A 5th `proc_valid` is ignored. Releasing ready drains the words in order 1..4.
- `flit_in`={1,3,0x12345678}, `flit_in_valid`=1, `proc_ready_in`=0 → `data_valid`=1, `ni_data`=0x12345678, `ni_src`=3 held until `proc_ready_in`=1, then one pop.
- Send 300 flits with dest=0 to NODE_ID=1 → none are delivered, `flit_in_ready` stays 1, `misroute_cnt` saturates at 255.
- With the RX FIFO full, issue a simultaneous pop and offered flit → the flit is refused that cycle and accepted the next; count stays 4, and order is preserved.
- Assert `rst` mid-stream with 2 entries in each FIFO → asynchronously `data_valid`=0, `flit_out_valid`=0, `mips_ni`=1, `flit_in_ready`=1, `misroute_cnt`=0.
